// File: rtl/tt4_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt4_sweep : drives all 16 {a,b,c,d} vectors, checks e_in vs EXPECT.          |
// | Rev 1.0   : optional observed-truth-table capture via TT4_SWEEP_CAPTURE_EN.  |
// +----------------------------------------------------------------------------+
module tt4_sweep #(
  parameter int          HOLD_CYCLES = 20,
  parameter logic [15:0] EXPECT      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        e_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        sample_strobe,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic [15:0] obs_tt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [4:0]  err_q, err_d;
  logic [3:0]  ferr_q, ferr_d;
  logic        w_launch;
  logic        w_strobe;
  logic        w_mismatch;

  assign w_launch   = (state_q != ST_DRIVE) && start;
  assign w_strobe   = (state_q == ST_DRIVE) && (hold_q == HOLD_LAST);
  assign w_mismatch = (e_in != EXPECT[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = 4'd0;
          hold_d  = 8'd0;
          err_d   = 5'd0;
          ferr_d  = 4'd0;
        end
      end
      ST_DRIVE: begin
        hold_d = hold_q + 8'd1;
        if (w_strobe) begin
          if (w_mismatch) begin
            err_d = err_q + 5'd1;
            if (err_q == 5'd0) begin
              ferr_d = idx_q;
            end
          end
          // The last vector stays on the pins once the sweep completes.
          if (idx_q == 4'hF) begin
            state_d = ST_DONE;
          end else begin
            idx_d  = idx_q + 4'd1;
            hold_d = 8'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      hold_q  <= 8'd0;
      err_q   <= 5'd0;
      ferr_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef TT4_SWEEP_CAPTURE_EN
  logic [15:0] obs_q, obs_d;

  always_comb begin
    obs_d = obs_q;
    if (w_launch) begin
      obs_d = 16'h0000;
    end else if (w_strobe) begin
      obs_d[idx_q] = e_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      obs_q <= 16'h0000;
    end else begin
      obs_q <= obs_d;
    end
  end

  assign obs_tt = obs_q;
`else
  assign obs_tt = 16'h0000;
`endif

  assign {a, b, c, d}   = idx_q;
  assign busy           = (state_q == ST_DRIVE);
  assign done           = (state_q == ST_DONE);
  assign sample_strobe  = w_strobe;
  assign pass           = done && (err_q == 5'd0);
  assign err_count      = err_q;
  assign first_err_idx  = ferr_q;

endmodule
`default_nettype wire
